// File: rtl/sata_wrapper_define.sv
// Shared SATA link-layer definitions used by both the transmit and receive
// sides: primitive/data type encoding, CRC constants, the transmit FSM state
// encoding and a one-dword CRC step helper.
package sata_wrapper_define;

  localparam logic [31:0] CRC_INIT = 32'h52325032;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  // Primitive currently on the wire; dat marks a payload or CRC dword.
  typedef enum logic [3:0] {
    sync, x_rdy, r_rdy, sof, eof, hold, holda, wtrm, r_ok, r_err, dat
  } sata_p_t;

  // One-hot transmit link states.
  typedef enum logic [8:0] {
    IDLE = 9'b000000001,
    XRDY = 9'b000000010,
    SOF  = 9'b000000100,
    DATA = 9'b000001000,
    HOLD = 9'b000010000,
    CRC  = 9'b000100000,
    EOF  = 9'b001000000,
    WTRM = 9'b010000000,
    DONE = 9'b100000000
  } tx_state_t;

  // Folds one 32-bit dword into the CRC, most significant bit first,
  // no reflection and no final inversion.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc_in,
                                             input logic [31:0] din);
    logic [31:0] c;
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ din[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_crc32.sv
// 32-bit parallel SATA CRC register (polynomial 04C11DB7).
// Ports:
//   clk, rst_n : clock and synchronous active-low reset (reset value CRC_INIT)
//   seed       : value loaded when init is high
//   init       : load seed (takes priority over en)
//   en         : fold din into the running CRC this cycle
//   din        : dword to fold
//   crc        : registered CRC over all dwords folded since the last init
module sata_crc32
  import sata_wrapper_define::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        init,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n)    crc <= CRC_INIT;
    else if (init) crc <= seed;
    else if (en)   crc <= crc32_step(crc, din);
  end

endmodule

// File: rtl/sata_link_tx.sv
// SATA link-layer transmit engine: negotiates a frame with X_RDY/R_RDY,
// sends SOF, payload with flow control, CRC, EOF, waits for R_OK/R_ERR and
// the closing SYNC, then reports completion.
// Ports:
//   clk, rst_n        : clock and synchronous active-low reset
//   wr_req            : grant from the link arbiter
//   wr_cpl, wr_ok     : one-cycle completion pulse and its good/bad qualifier
//   wr_no_busy        : block may be pre-empted (IDLE or XRDY)
//   phyrdy            : PHY ready
//   rx_dat_type       : primitive decoded from the device
//   tx_dat/vld/last   : payload stream from transport, accepted with tx_rdy
//   tx_p_type/tx_p_dat: item to transmit this cycle
module sata_link_tx
  import sata_wrapper_define::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  output logic        wr_cpl,
  output logic        wr_no_busy,
  output logic        wr_ok,
  input  logic        phyrdy,
  input  sata_p_t     rx_dat_type,
  input  logic [31:0] tx_dat,
  input  logic        tx_vld,
  input  logic        tx_last,
  output logic        tx_rdy,
  output sata_p_t     tx_p_type,
  output logic [31:0] tx_p_dat
);

  tx_state_t   state, state_nxt;
  logic        cpl_nxt, ok_nxt;
  logic        xfer;
  logic        rx_ok_q;
  logic [31:0] crc;

  // Abort condition shared by every state past XRDY.
  logic        drop;
  assign drop = !phyrdy || (rx_dat_type == sync);

  sata_crc32 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (CRC_INIT),
    .init  (state == SOF),
    .en    (xfer),
    .din   (tx_dat),
    .crc   (crc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_cpl  <= 1'b0;
      wr_ok   <= 1'b0;
      rx_ok_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_cpl <= cpl_nxt;
      wr_ok  <= ok_nxt;
      // The last WTRM cycle carries the device's verdict into DONE.
      if (state == WTRM) rx_ok_q <= (rx_dat_type == r_ok);
    end
  end

  always_comb begin
    state_nxt = state;
    cpl_nxt   = 1'b0;
    ok_nxt    = 1'b0;
    tx_p_type = sync;
    tx_p_dat  = '0;
    tx_rdy    = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && phyrdy) state_nxt = XRDY;
      end
      XRDY: begin
        tx_p_type = x_rdy;
        // Back-off and PHY loss before SOF end silently, without a completion.
        if (!phyrdy || !wr_req)        state_nxt = IDLE;
        else if (rx_dat_type == r_rdy) state_nxt = SOF;
      end
      SOF: begin
        tx_p_type = sof;
        if (drop) begin state_nxt = IDLE; cpl_nxt = 1'b1; end
        else      state_nxt = DATA;
      end
      DATA: begin
        tx_rdy = 1'b1;
        xfer   = tx_vld;
        if (tx_vld) begin
          tx_p_type = dat;
          tx_p_dat  = tx_dat;
        end else begin
          tx_p_type = hold;
        end
        // A last dword beats a simultaneous rx hold so CRC/EOF stay together.
        if (drop)                      begin state_nxt = IDLE; cpl_nxt = 1'b1; end
        else if (tx_vld && tx_last)    state_nxt = CRC;
        else if (rx_dat_type == hold)  state_nxt = HOLD;
      end
      HOLD: begin
        tx_p_type = holda;
        if (drop)                      begin state_nxt = IDLE; cpl_nxt = 1'b1; end
        else if (rx_dat_type != hold)  state_nxt = DATA;
      end
      CRC: begin
        tx_p_type = dat;
        tx_p_dat  = crc;
        if (drop) begin state_nxt = IDLE; cpl_nxt = 1'b1; end
        else      state_nxt = EOF;
      end
      EOF: begin
        tx_p_type = eof;
        if (drop) begin state_nxt = IDLE; cpl_nxt = 1'b1; end
        else      state_nxt = WTRM;
      end
      WTRM: begin
        tx_p_type = wtrm;
        if (drop) begin state_nxt = IDLE; cpl_nxt = 1'b1; end
        else if (rx_dat_type == r_ok || rx_dat_type == r_err) state_nxt = DONE;
      end
      DONE: begin
        tx_p_type = sync;
        if (!phyrdy) begin
          state_nxt = IDLE;
          cpl_nxt   = 1'b1;
        end else if (rx_dat_type == sync) begin
          state_nxt = IDLE;
          cpl_nxt   = 1'b1;
          ok_nxt    = rx_ok_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_no_busy = (state == IDLE) || (state == XRDY);

endmodule
